// File: rtl/input_cond_pkg.sv
// Shared types and board-derived defaults for the board-input conditioner.
// Per-channel state encoding plus cycle counts derived from the 100 MHz board clock.
package input_cond_pkg;

  localparam int CLK_HZ           = 100_000_000;
  localparam int DEF_DEBOUNCE_CYC = CLK_HZ / 100;
  localparam int DEF_LONG_CYC     = CLK_HZ;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_PEND,
    PRESSED,
    LONG,
    REL_PEND
  } ch_state_e;

  // Accepted (debounced) level implied by a channel state.
  function automatic logic state_level(input ch_state_e s);
    return (s == PRESSED) || (s == LONG) || (s == REL_PEND);
  endfunction

  function automatic int cnt_width(input int deb, input int lng);
    return $clog2(((deb > lng) ? deb : lng) + 1);
  endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One input bit: 2-FF sync, debounce, press/release pulses, long-press; level lags a clean
// step by 2+DEBOUNCE_CYC cycles, all outputs registered, no flow control.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic norm_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic held
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC, LONG_CYC);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);

  ch_state_e        state_q, state_d;
  logic             sync0_q, sync0_d, sync1_q, sync1_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d, long_cnt_q, long_cnt_d;
  logic             press_q, press_d, release_q, release_d;
  logic             long_press_q, long_press_d, held_q, held_d;
  logic             lvl_cur, lvl_nxt, pending, accept, fire, long_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync0_q      <= 1'b0;
      sync1_q      <= 1'b0;
      deb_cnt_q    <= '0;
      long_cnt_q   <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync0_q      <= sync0_d;
      sync1_q      <= sync1_d;
      deb_cnt_q    <= deb_cnt_d;
      long_cnt_q   <= long_cnt_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_press_q <= long_press_d;
      held_q       <= held_d;
    end
  end

  always_comb begin
    sync0_d   = norm_in;
    sync1_d   = sync0_q;
    lvl_cur   = state_level(state_q);
    pending   = (sync1_q != lvl_cur);
    accept    = pending && (deb_cnt_q == DEB_LAST);
    deb_cnt_d = (pending && !accept) ? deb_cnt_q + 1'b1 : '0;
    fire      = lvl_cur && (long_cnt_q == LONG_LAST);
    long_ok   = held_q || fire;

    state_d = state_q;
    case (state_q)
      IDLE:       if (accept) state_d = PRESSED; else if (pending) state_d = PRESS_PEND;
      PRESS_PEND: if (accept) state_d = PRESSED; else if (!pending) state_d = IDLE;
      PRESSED: begin
        if (accept)       state_d = IDLE;
        else if (pending) state_d = REL_PEND;
        else if (fire)    state_d = LONG;
      end
      LONG:       if (accept) state_d = IDLE; else if (pending) state_d = REL_PEND;
      // A glitch during release returns to whichever pressed state we left.
      REL_PEND: begin
        if (accept)        state_d = IDLE;
        else if (!pending) state_d = long_ok ? LONG : PRESSED;
      end
      default:    state_d = IDLE;
    endcase

    lvl_nxt      = state_level(state_d);
    press_d      = lvl_nxt && !lvl_cur;
    release_d    = !lvl_nxt && lvl_cur;
    long_press_d = fire && lvl_nxt;
    held_d       = lvl_nxt && long_ok;
    if (lvl_cur && lvl_nxt)
      long_cnt_d = (long_cnt_q == LONG_MAX) ? long_cnt_q : long_cnt_q + 1'b1;
    else
      long_cnt_d = '0;
  end

  always_comb begin
    level         = state_level(state_q);
    press         = press_q;
    release_pulse = release_q;
    long_press    = long_press_q;
    held          = held_q;
  end

endmodule

// File: rtl/input_conditioner.sv
// N-channel board-input front end: polarity normalisation then one independent channel per bit.
// Latency 2+DEBOUNCE_CYC cycles from pin to level; no flow control.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int              N_CH         = 4,
  parameter int              DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int              LONG_CYC     = DEF_LONG_CYC,
  parameter logic [N_CH-1:0] ACTIVE_LOW   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  // Release pulse; 'release' itself is a reserved word.
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] held
);

  logic [N_CH-1:0] norm;

  assign norm = raw_in ^ ACTIVE_LOW;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    input_cond_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .norm_in       (norm[g]),
      .level         (level[g]),
      .press         (press[g]),
      .release_pulse (release_pulse[g]),
      .long_press    (long_press[g]),
      .held          (held[g])
    );
  end

endmodule
